// File: rtl/common_types_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
package common_types_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HSIZE_BYTE = 2'b00;
  localparam logic [1:0] HSIZE_HALF = 2'b01;
  localparam logic [1:0] HSIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_strobe_gen.sv
// Little-endian byte-lane mask for an AHB transfer, plus a flag for
// sizes that do not fit their address alignment (or the reserved size).
module ahb_strobe_gen
  import common_types_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] strobe,
  output logic       misalign
);

  always_comb begin
    strobe   = 4'b0000;
    misalign = 1'b0;
    case (size)
      HSIZE_BYTE: strobe = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        strobe   = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      HSIZE_WORD: begin
        strobe   = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word array with byte-lane writes, optional data-phase
// wait states and a two-cycle ERROR response for illegal transfers.
module ahb_sram_slave
  import common_types_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [1:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t           state_reg, state_next;
  logic [3:0]       wait_cnt_reg;
  logic [31:0]      addr_reg;
  logic             write_reg;
  logic [1:0]       size_reg;
  logic             hreadyout_reg, hresp_reg, rd_valid_reg;
  logic [3:0]       fwd_strobe_reg;
  logic [31:0]      fwd_data_reg, ram_q;
  logic [31:0]      mem [MEM_WORDS];

  logic [3:0]       live_strobe, data_strobe;
  logic             live_misalign, data_misalign;
  logic [31:0]      live_offset, data_offset;
  logic [IDX_W-1:0] live_idx, data_idx, rd_idx;
  logic             accept, illegal, wr_en, rd_en;
  logic             unused_bits;

  ahb_strobe_gen u_live_strobe (
    .size    (hsize),
    .addr_lo (haddr[1:0]),
    .strobe  (live_strobe),
    .misalign(live_misalign)
  );

  ahb_strobe_gen u_data_strobe (
    .size    (size_reg),
    .addr_lo (addr_reg[1:0]),
    .strobe  (data_strobe),
    .misalign(data_misalign)
  );

  assign live_offset = haddr - BASE_ADDR;
  assign data_offset = addr_reg - BASE_ADDR;
  assign live_idx    = live_offset[IDX_W+1:2];
  assign data_idx    = data_offset[IDX_W+1:2];

  // A new address phase is only taken while this slave is not stalling the bus.
  assign accept  = hsel && hready && is_active(htrans) &&
                   (state_reg == S_IDLE || state_reg == S_DATA || state_reg == S_ERR2);
  assign illegal = live_misalign || (live_offset >= MEM_BYTES);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_WAIT: if (wait_cnt_reg == 4'd0) state_next = S_DATA;
      S_ERR1: state_next = S_ERR2;
      default: begin
        if (!accept)              state_next = S_IDLE;
        else if (illegal)         state_next = S_ERR1;
        else if (WAIT_STATES > 0) state_next = S_WAIT;
        else                      state_next = S_DATA;
      end
    endcase
  end

  assign wr_en  = (state_reg == S_DATA) && write_reg;
  // Without wait states the read is launched straight from the live address phase.
  assign rd_idx = (WAIT_STATES > 0) ? data_idx : live_idx;
  assign rd_en  = (state_next == S_DATA) && ((WAIT_STATES > 0) ? !write_reg : !hwrite);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg      <= S_IDLE;
      wait_cnt_reg   <= 4'd0;
      addr_reg       <= 32'd0;
      write_reg      <= 1'b0;
      size_reg       <= 2'b00;
      hreadyout_reg  <= 1'b1;
      hresp_reg      <= 1'b0;
      rd_valid_reg   <= 1'b0;
      fwd_strobe_reg <= 4'b0000;
      fwd_data_reg   <= 32'd0;
    end else begin
      state_reg     <= state_next;
      hreadyout_reg <= !(state_next == S_WAIT || state_next == S_ERR1);
      hresp_reg     <= (state_next == S_ERR1 || state_next == S_ERR2);
      rd_valid_reg  <= rd_en;
      // Lanes written on the same edge a read samples the array bypass the stale RAM data.
      fwd_strobe_reg <= (rd_en && wr_en && data_idx == rd_idx) ? data_strobe : 4'b0000;
      fwd_data_reg   <= hwdata;
      if (accept) begin
        addr_reg     <= haddr;
        write_reg    <= hwrite;
        size_reg     <= hsize;
        wait_cnt_reg <= WAIT_LOAD;
      end else if (state_reg == S_WAIT && wait_cnt_reg != 4'd0) begin
        wait_cnt_reg <= wait_cnt_reg - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (data_strobe[b]) mem[data_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
    if (rd_en) ram_q <= mem[rd_idx];
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign hrdata[8*gi +: 8] = !rd_valid_reg      ? 8'h00 :
                                 fwd_strobe_reg[gi] ? fwd_data_reg[8*gi +: 8] :
                                                      ram_q[8*gi +: 8];
    end
  endgenerate

  assign hreadyout = hreadyout_reg;
  assign hresp     = hresp_reg;

  assign unused_bits = ^{hburst, live_strobe, data_misalign,
                         live_offset[31:IDX_W+2], live_offset[1:0],
                         data_offset[31:IDX_W+2], data_offset[1:0]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Two slaves on one AHB bus (0 and 3 wait states); pipelined transfers are
// checked every data-phase cycle against a word-array reference model.
module tb_ahb_sram_slave;
  import common_types_pkg::*;

  localparam int          MW   = 64;
  localparam logic [31:0] BASE = 32'h0000_0000;

  typedef struct packed {
    logic        idle;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        write;
    logic [31:0] data;
  } xfer_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        hsel_drv = 1'b0;
  bit          tgt = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0]  htrans = HTRANS_IDLE, hsize = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hburst = '0;
  logic [31:0] rdata0, rdata3, rdata;
  logic        ro0, ro3, resp0, resp3, ro, resp, hsel0, hsel3;

  int          n_cmp = 0, n_bad = 0;
  xfer_t       q[$];
  logic [31:0] mdl [2][MW];
  bit          known [2][MW];

  always #5 clk = ~clk;

  assign hsel0 = hsel_drv && !tgt;
  assign hsel3 = hsel_drv && tgt;
  assign ro    = tgt ? ro3 : ro0;
  assign resp  = tgt ? resp3 : resp0;
  assign rdata = tgt ? rdata3 : rdata0;

  ahb_sram_slave #(.MEM_WORDS(MW), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_dut0 (
    .clk(clk), .nrst(nrst), .hsel(hsel0), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(ro),
    .hrdata(rdata0), .hreadyout(ro0), .hresp(resp0));

  ahb_sram_slave #(.MEM_WORDS(MW), .WAIT_STATES(3), .BASE_ADDR(BASE)) u_dut3 (
    .clk(clk), .nrst(nrst), .hsel(hsel3), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(ro),
    .hrdata(rdata3), .hreadyout(ro3), .hresp(resp3));

  function automatic void push_wr(logic [31:0] a, logic [1:0] s, logic [31:0] d);
    xfer_t x;
    x = '0; x.addr = a; x.size = s; x.write = 1'b1; x.data = d;
    q.push_back(x);
  endfunction

  function automatic void push_rd(logic [31:0] a, logic [1:0] s);
    xfer_t x;
    x = '0; x.addr = a; x.size = s;
    q.push_back(x);
  endfunction

  function automatic void push_idle(int n);
    xfer_t x;
    for (int i = 0; i < n; i++) begin
      x = '0; x.idle = 1'b1; x.addr = $urandom();
      q.push_back(x);
    end
  endfunction

  function automatic bit is_illegal(logic [31:0] a, logic [1:0] s);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00) ||
           ((a - BASE) >= 32'(MW * 4));
  endfunction

  function automatic void model_write(int d, logic [31:0] a, logic [1:0] s, logic [31:0] v);
    int w  = int'((a - BASE) >> 2);
    int lo = int'(a[1:0]);
    for (int k = 0; k < 4; k++) begin
      if (s == 2'b10 || (s == 2'b01 && k / 2 == lo / 2) || (s == 2'b00 && k == lo))
        mdl[d][w][8*k +: 8] = v[8*k +: 8];
    end
    if (s == 2'b10) known[d][w] = 1'b1;
  endfunction

  task automatic run_queue(input string name);
    xfer_t       dp;
    bit          dp_v = 1'b0, exp_ro, exp_resp, chk_rd, ill;
    int          dcyc = 0, cyc = 0, w;
    int          d  = tgt ? 1 : 0;
    int          ws = tgt ? 3 : 0;
    logic [31:0] exp_rd;
    dp = '0;
    while (q.size() > 0 || dp_v) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000 || dcyc > 40) begin
        n_cmp++; n_bad++;
        $display("FAIL %s timeout: hreadyout=%0b after %0d cycles, want transfer completion", name, ro, cyc);
        q.delete();
        break;
      end
      hwdata = (dp_v && dp.write) ? dp.data : $urandom();
      exp_ro = 1'b1; exp_resp = 1'b0; exp_rd = '0; chk_rd = 1'b1; ill = 1'b0;
      if (dp_v && !dp.idle) begin
        ill = is_illegal(dp.addr, dp.size);
        if (ill) begin
          exp_resp = 1'b1;
          exp_ro   = (dcyc >= 1);
        end else begin
          exp_ro = (dcyc >= ws);
          if (exp_ro && !dp.write) begin
            w      = int'((dp.addr - BASE) >> 2);
            exp_rd = mdl[d][w];
            chk_rd = known[d][w];
          end
        end
      end
      n_cmp++;
      if (ro !== exp_ro) begin
        n_bad++;
        $display("FAIL %s hreadyout cyc %0d addr %08h: got %0b want %0b", name, cyc, dp.addr, ro, exp_ro);
      end
      n_cmp++;
      if (resp !== exp_resp) begin
        n_bad++;
        $display("FAIL %s hresp cyc %0d addr %08h: got %0b want %0b", name, cyc, dp.addr, resp, exp_resp);
      end
      if (chk_rd) begin
        n_cmp++;
        if (rdata !== exp_rd) begin
          n_bad++;
          $display("FAIL %s hrdata cyc %0d addr %08h: got %08h want %08h", name, cyc, dp.addr, rdata, exp_rd);
        end
      end
      if (dp_v) begin
        if (ro === 1'b1) begin
          $display("[%s] dut%0d %s addr=%08h size=%0d data=%08h hresp=%0b", name, ws,
                   dp.idle ? "IDLE" : (dp.write ? "WR  " : "RD  "), dp.addr, dp.size,
                   dp.write ? dp.data : rdata, resp);
          if (!dp.idle && dp.write && !ill) model_write(d, dp.addr, dp.size, dp.data);
          dp_v = 1'b0;
        end else begin
          dcyc++;
        end
      end
      if (q.size() > 0) begin
        hsel_drv = 1'b1;
        haddr    = q[0].addr;
        hwrite   = q[0].write;
        hsize    = q[0].size;
        hburst   = 3'($urandom());
        htrans   = q[0].idle ? HTRANS_IDLE : ($urandom_range(0, 1) ? HTRANS_SEQ : HTRANS_NONSEQ);
      end else begin
        hsel_drv = 1'b0;
        htrans   = HTRANS_IDLE;
      end
      if (ro === 1'b1 && q.size() > 0) begin
        dp = q.pop_front(); dp_v = 1'b1; dcyc = 0;
      end
    end
    hsel_drv = 1'b0;
    htrans   = HTRANS_IDLE;
  endtask

  task automatic test_reset();
    #1 nrst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 6;
    if (ro0 !== 1'b1)      begin n_bad++; $display("FAIL reset ro0: got %0b want 1", ro0); end
    if (resp0 !== 1'b0)    begin n_bad++; $display("FAIL reset resp0: got %0b want 0", resp0); end
    if (rdata0 !== 32'd0)  begin n_bad++; $display("FAIL reset rdata0: got %08h want 0", rdata0); end
    if (ro3 !== 1'b1)      begin n_bad++; $display("FAIL reset ro3: got %0b want 1", ro3); end
    if (resp3 !== 1'b0)    begin n_bad++; $display("FAIL reset resp3: got %0b want 0", resp3); end
    if (rdata3 !== 32'd0)  begin n_bad++; $display("FAIL reset rdata3: got %08h want 0", rdata3); end
    nrst = 1'b1;
  endtask

  task automatic test_back_to_back();
    tgt = 1'b0;
    push_wr(32'h10, HSIZE_WORD, 32'hDEAD_BEEF);
    push_rd(32'h10, HSIZE_WORD);
    run_queue("back_to_back");
  endtask

  task automatic test_wait_states();
    tgt = 1'b1;
    push_wr(32'h20, HSIZE_WORD, $urandom());
    push_idle(2);
    push_rd(32'h20, HSIZE_WORD);
    push_rd(32'h20, HSIZE_BYTE);
    run_queue("wait_states");
  endtask

  task automatic test_lanes();
    tgt = 1'b0;
    push_wr(32'h04, HSIZE_WORD, 32'h1122_3344);
    push_rd(32'h04, HSIZE_WORD);
    push_wr(32'h06, HSIZE_BYTE, {8'($urandom()), 8'hAA, 16'($urandom())});
    push_rd(32'h04, HSIZE_WORD);
    push_wr(32'h04, HSIZE_HALF, {16'($urandom()), 16'hBEEF});
    push_rd(32'h04, HSIZE_WORD);
    run_queue("lanes");
  endtask

  task automatic test_errors();
    tgt = 1'b0;
    push_wr(32'h05, HSIZE_HALF, $urandom());
    push_rd(32'h04, HSIZE_WORD);
    push_wr(32'(MW * 4), HSIZE_WORD, $urandom());
    push_rd(32'h05, HSIZE_HALF);
    push_wr(32'h04, 2'b11, $urandom());
    push_rd(32'h04, HSIZE_WORD);
    push_wr(32'(MW * 4 - 4), HSIZE_WORD, $urandom());
    push_rd(32'(MW * 4 - 4), HSIZE_WORD);
    run_queue("errors");
  endtask

  task automatic test_idle_gap();
    for (int d = 0; d < 2; d++) begin
      tgt = (d == 1);
      push_wr(32'h30, HSIZE_WORD, $urandom());
      push_idle(5);
      push_rd(32'h30, HSIZE_WORD);
      run_queue("idle_gap");
    end
  endtask

  task automatic test_reset_in_wait();
    tgt = 1'b1;
    push_wr(32'h14, HSIZE_WORD, 32'hCAFE_0014);
    run_queue("rst_pre");
    @(negedge clk);
    hsel_drv = 1'b1; haddr = 32'h14; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
    hwdata = 32'h5555_AAAA;
    @(negedge clk);
    hsel_drv = 1'b0; htrans = HTRANS_IDLE;
    @(posedge clk);
    #2;
    n_cmp++;
    if (ro3 !== 1'b0) begin n_bad++; $display("FAIL rst_wait stall: got hreadyout %0b want 0", ro3); end
    nrst = 1'b0;
    #1;
    n_cmp += 2;
    if (ro3 !== 1'b1)   begin n_bad++; $display("FAIL rst_wait ready: got %0b want 1", ro3); end
    if (resp3 !== 1'b0) begin n_bad++; $display("FAIL rst_wait resp: got %0b want 0", resp3); end
    $display("[rst_wait] dut3 reset asserted in second wait cycle of write to 00000014");
    @(negedge clk);
    nrst = 1'b1;
    push_rd(32'h14, HSIZE_WORD);
    run_queue("rst_post");
  endtask

  task automatic test_random();
    int r, w, off;
    for (int d = 0; d < 2; d++) begin
      tgt = (d == 1);
      for (int i = 0; i < 16; i++) push_wr(32'(i * 4), HSIZE_WORD, $urandom());
      for (int i = 0; i < 60; i++) begin
        r   = $urandom_range(0, 9);
        w   = $urandom_range(0, 15);
        off = $urandom_range(0, 3);
        case (r)
          0, 1, 2:    push_wr(32'(w * 4 + off), 2'($urandom_range(0, 2)), $urandom());
          3, 4, 5, 6: push_rd(32'(w * 4 + off), 2'($urandom_range(0, 2)));
          7:          if ($urandom_range(0, 1) == 1) push_wr(32'(w * 4), 2'b11, $urandom());
                      else push_rd(32'(w * 4), 2'b11);
          8:          push_wr($urandom_range(0, 1) ? 32'(MW * 4 + 4 * $urandom_range(0, 15)) : 32'hFFFF_FFFC,
                              HSIZE_WORD, $urandom());
          default:    push_idle($urandom_range(1, 3));
        endcase
      end
      run_queue("random");
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_lanes();
    test_errors();
    test_idle_gap();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
